// File: rtl/apb_master.sv
// APB master: turns one command at a time into an APB SETUP/ACCESS transfer
// and reports completion with a one-cycle rsp_valid pulse.
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort transfers that stay in
// ACCESS for TIMEOUT_CYCLES cycles (reported with rsp_err=1).
module apb_master #(
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned DATA_W         = 4,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e state_q, state_d;
  logic   xfer_done;
  logic   xfer_abort;

  assign xfer_done = (state_q == StAccess) && pready;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q;

  // Abort on the edge where the wait counter would reach TIMEOUT_CYCLES;
  // pready on that same edge wins and completes normally.
  assign xfer_abort = (state_q == StAccess) && !pready &&
                      (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  // Wait-state counter: cleared while in SETUP (i.e. on entry to ACCESS).
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      cnt_q <= '0;
    end else if (state_q == StSetup) begin
      cnt_q <= '0;
    end else if ((state_q == StAccess) && !pready) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Error flag rides along with the rsp_valid pulse of an aborted transfer.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      rsp_err <= 1'b0;
    end else begin
      rsp_err <= xfer_abort;
    end
  end
`else
  logic unused_timeout;

  assign xfer_abort     = 1'b0;
  assign rsp_err        = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // State register.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and APB/handshake outputs, decoded from the current state.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = StSetup;
      end
      StSetup: begin
        psel    = 1'b1;
        state_d = StAccess;
      end
      StAccess: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready || xfer_abort) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Command capture: APB address/data only change when a command is accepted.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      pwrite <= 1'b0;
      paddr  <= '0;
      pwdata <= '0;
    end else if ((state_q == StIdle) && cmd_valid) begin
      pwrite <= cmd_write;
      paddr  <= cmd_addr;
      pwdata <= cmd_write ? cmd_wdata : '0;
    end
  end

  // Response: one-cycle valid pulse; read data held until the next completed read.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= xfer_done || xfer_abort;
      if (xfer_done && !pwrite) rsp_rdata <= prdata;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: table of transfers plus hand-written
// reset and timeout sequences; responses are checked against a scoreboard.
module tb_apb_master;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 4;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned TimeoutCycles = 4;
`else
  localparam int unsigned TimeoutCycles = 15;
`endif

  logic          pclk = 1'b0;
  logic          prst = 1'b1;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr, paddr;
  logic [DW-1:0] cmd_wdata, rsp_rdata, pwdata, prdata;
  logic          rsp_valid, rsp_err, psel, penable, pwrite, pready;

  apb_master #(
    .ADDR_W        (AW),
    .DATA_W        (DW),
    .TIMEOUT_CYCLES(TimeoutCycles)
  ) dut (
    .pclk     (pclk),
    .prst     (prst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .pready   (pready),
    .prdata   (prdata)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [DW-1:0] rdata;
    logic        err;
  } rsp_t;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;
    logic [DW-1:0] prdata;
    bit            b2b;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  rsp_t sb[$];
  vec_t vec[7];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_rsp   = 0;
  int   n_exp   = 0;

  logic          last_wr;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_pwdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard side: every rsp_valid pulse must match the oldest expectation.
  always @(negedge pclk) begin
    rsp_t e;
    if (!prst) begin
      if (rsp_valid) begin
        n_rsp++;
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 0);
        end else begin
          e = sb.pop_front();
          check("rsp_cycle", cyc, e.cyc);
          check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
          check("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end else begin
        check("rsp_err_idle", 32'(rsp_err), 0);
      end
    end
  end

  // One IDLE cycle with no command: APB idle, last address/data held.
  task automatic idle_tick();
    @(negedge pclk);
    check("gap_psel", 32'(psel), 0);
    check("gap_penable", 32'(penable), 0);
    check("gap_cmd_ready", 32'(cmd_ready), 1);
    check("gap_paddr_hold", 32'(paddr), 32'(last_addr));
    check("gap_pwrite_hold", 32'(pwrite), 32'(last_wr));
    check("gap_pwdata_hold", 32'(pwdata), 32'(last_pwdata));
    @(posedge pclk); #1;
  endtask

  // Drives one command from IDLE and plays the slave. Called #1 after a posedge.
  task automatic do_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input int waits, input logic [DW-1:0] rd, input bit abort,
                         input logic [DW-1:0] exp_rdata);
    rsp_t          e;
    logic [DW-1:0] exp_pw;
    int            n_acc;
    exp_pw    = wr ? wd : '0;
    n_acc     = abort ? int'(TimeoutCycles) : waits + 1;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    pready    = 1'b1;  // ignored outside ACCESS
    prdata    = ~rd;
    @(negedge pclk);
    check("idle_cmd_ready", 32'(cmd_ready), 1);
    check("idle_psel", 32'(psel), 0);
    check("idle_penable", 32'(penable), 0);
    check("idle_paddr_hold", 32'(paddr), 32'(last_addr));
    check("idle_pwdata_hold", 32'(pwdata), 32'(last_pwdata));
    e.cyc   = cyc + 2 + n_acc;
    e.rdata = exp_rdata;
    e.err   = abort;
    sb.push_back(e);
    n_exp++;
    @(posedge pclk); #1;
    // cmd_valid stays high with junk fields; it must be ignored until IDLE.
    cmd_write = ~wr;
    cmd_addr  = ~addr;
    cmd_wdata = ~wd;
    @(negedge pclk);
    check("setup_psel", 32'(psel), 1);
    check("setup_penable", 32'(penable), 0);
    check("setup_cmd_ready", 32'(cmd_ready), 0);
    check("setup_paddr", 32'(paddr), 32'(addr));
    check("setup_pwrite", 32'(pwrite), 32'(wr));
    check("setup_pwdata", 32'(pwdata), 32'(exp_pw));
    @(posedge pclk); #1;
    for (int i = 0; i < n_acc; i++) begin
      pready = !abort && (i == n_acc - 1);
      prdata = pready ? rd : ~rd;
      @(negedge pclk);
      check("access_psel", 32'(psel), 1);
      check("access_penable", 32'(penable), 1);
      check("access_cmd_ready", 32'(cmd_ready), 0);
      check("access_paddr", 32'(paddr), 32'(addr));
      check("access_pwrite", 32'(pwrite), 32'(wr));
      check("access_pwdata", 32'(pwdata), 32'(exp_pw));
      @(posedge pclk); #1;
    end
    cmd_valid   = 1'b0;
    pready      = 1'b0;
    last_wr     = wr;
    last_addr   = addr;
    last_pwdata = exp_pw;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_addr    = '0;
    cmd_wdata   = '0;
    pready      = 1'b0;
    prdata      = '0;
    last_wr     = 1'b0;
    last_addr   = '0;
    last_pwdata = '0;

    //           wr    addr  wdata waits prdata b2b   exp_rdata
    vec[0] = '{1'b1, 4'h5, 4'hA, 0, 4'h0, 1'b0, 4'h0};  // zero-wait write
    vec[1] = '{1'b0, 4'h3, 4'h9, 2, 4'h7, 1'b0, 4'h7};  // read, 2 wait states
    vec[2] = '{1'b1, 4'h1, 4'h6, 0, 4'h0, 1'b0, 4'h7};  // write keeps rdata
    vec[3] = '{1'b1, 4'h2, 4'hC, 1, 4'h0, 1'b1, 4'h7};  // back-to-back write
    vec[4] = '{1'b0, 4'hF, 4'h3, 0, 4'h0, 1'b1, 4'h0};  // back-to-back read
    vec[5] = '{1'b0, 4'h8, 4'h0, 4, 4'h5, 1'b0, 4'h5};
    vec[6] = '{1'b1, 4'h0, 4'hF, 0, 4'h0, 1'b1, 4'h5};

    repeat (2) @(posedge pclk);
    #1;
    check("rst_psel", 32'(psel), 0);
    check("rst_penable", 32'(penable), 0);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_pwrite", 32'(pwrite), 0);
    check("rst_paddr", 32'(paddr), 0);
    check("rst_pwdata", 32'(pwdata), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 0);
    check("rst_rsp_err", 32'(rsp_err), 0);
    prst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      if (!vec[i].b2b) idle_tick();
      do_xfer(vec[i].wr, vec[i].addr, vec[i].wdata, vec[i].waits, vec[i].prdata, 1'b0,
              vec[i].exp_rdata);
    end
    idle_tick();

    // Reset in the middle of ACCESS: abandon without a response.
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 4'h6;
    cmd_wdata = 4'h3;
    pready    = 1'b0;
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    @(negedge pclk);
    check("mid_penable_before_rst", 32'(penable), 1);
    #2;
    prst = 1'b1;
    #1;
    check("mid_rst_psel", 32'(psel), 0);
    check("mid_rst_penable", 32'(penable), 0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 1);
    check("mid_rst_paddr", 32'(paddr), 0);
    check("mid_rst_pwdata", 32'(pwdata), 0);
    check("mid_rst_rsp_rdata", 32'(rsp_rdata), 0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    @(posedge pclk); #1;
    prst        = 1'b0;
    last_wr     = 1'b0;
    last_addr   = '0;
    last_pwdata = '0;
    do_xfer(1'b0, 4'h3, 4'h0, 0, 4'h9, 1'b0, 4'h9);

`ifdef APB_MASTER_TIMEOUT_EN
    // pready never comes: abort after TimeoutCycles ACCESS cycles, rdata unchanged.
    do_xfer(1'b0, 4'h4, 4'h0, 0, 4'h1, 1'b1, 4'h9);
    idle_tick();
    // pready on the edge where the counter reaches the limit completes normally.
    do_xfer(1'b0, 4'h5, 4'h0, int'(TimeoutCycles) - 1, 4'h2, 1'b0, 4'h2);
`else
    // Without the timeout, ACCESS waits as long as the slave needs.
    do_xfer(1'b0, 4'h5, 4'h0, 20, 4'h4, 1'b0, 4'h4);
`endif
    repeat (2) idle_tick();

    check("sb_drained", sb.size(), 0);
    check("rsp_count", n_rsp, n_exp);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
